// File: rtl/axil_gfi_fifo_kopru.sv
// AXI4-Lite slave bridging the CPU bus to a coprocessor's GFA komut/veri ports.
// Command FIFO is filled by AXI writes to 0x0; the data FIFO is drained by AXI
// reads of 0x0; 0x4 reads a status word; every other access gets SLVERR.
`timescale 1ns/1ps
module axil_gfi_fifo_kopru #(
    parameter int         ADRES_BIT  = 32,
    parameter int         VERI_BIT   = 32,
    parameter int         KOMUT_DER  = 4,
    parameter int         VERI_DER   = 4,
    parameter logic [7:0] STRB_DOLGU = 8'hFF
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ADRES_BIT-1:0]    AWADDR,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [VERI_BIT-1:0]     WDATA,
    input  logic [VERI_BIT/8-1:0]   WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic                    BVALID,
    output logic [1:0]              BRESP,
    input  logic                    BREADY,
    input  logic [ADRES_BIT-1:0]    ARADDR,
    input  logic [2:0]              ARPROT,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [VERI_BIT-1:0]     RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [VERI_BIT-1:0]     komut,
    output logic                    komut_gecerli,
    input  logic                    komut_hazir,
    input  logic [VERI_BIT-1:0]     veri,
    input  logic                    veri_gecerli,
    output logic                    veri_hazir
);

    localparam int unsigned     NB     = VERI_BIT / 8;
    localparam int              KPW    = (KOMUT_DER > 1) ? $clog2(KOMUT_DER) : 1;
    localparam int              VPW    = (VERI_DER > 1) ? $clog2(VERI_DER) : 1;
    localparam logic [7:0]      K_DER8 = 8'(KOMUT_DER);
    localparam logic [7:0]      V_DER8 = 8'(VERI_DER);
    localparam logic [KPW-1:0]  K_SON  = KPW'(KOMUT_DER - 1);
    localparam logic [VPW-1:0]  V_SON  = VPW'(VERI_DER - 1);

    // Write-side holding registers
    logic                   aw_tutuldu, w_tutuldu;
    logic [1:0]             aw_adr;
    logic [VERI_BIT-1:0]    w_veri;
    logic [NB-1:0]          w_strb;
    logic [VERI_BIT-1:0]    k_birlesik;

    // FIFO storage and bookkeeping
    logic [VERI_BIT-1:0]    k_mem [KOMUT_DER];
    logic [VERI_BIT-1:0]    v_mem [VERI_DER];
    logic [KPW-1:0]         k_yaz, k_oku;
    logic [VPW-1:0]         v_yaz, v_oku;
    logic [7:0]             k_say, v_say;

    logic aw_hs, w_hs, ar_hs, yaz_hazir;
    logic k_push, k_pop, v_push, v_pop, k_dolu, v_bos, v_dolu;
    logic [31:0] durum;

    // AWPROT/ARPROT and undecoded address bits carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{AWPROT, ARPROT, AWADDR[ADRES_BIT-1:4], AWADDR[1:0],
                         ARADDR[ADRES_BIT-1:4], ARADDR[1:0]};

    assign AWREADY       = ARESETn & ~aw_tutuldu & ~BVALID;
    assign WREADY        = ARESETn & ~w_tutuldu & ~BVALID;
    assign ARREADY       = ARESETn & ~RVALID;
    assign aw_hs         = AWVALID & AWREADY;
    assign w_hs          = WVALID & WREADY;
    assign ar_hs         = ARVALID & ARREADY;

    assign k_dolu        = (k_say == K_DER8);
    assign v_bos         = (v_say == 8'd0);
    assign v_dolu        = (v_say == V_DER8);
    assign komut_gecerli = (k_say != 8'd0);
    assign komut         = komut_gecerli ? k_mem[k_oku] : '0;
    assign veri_hazir    = ARESETn & ~v_dolu;

    assign yaz_hazir     = aw_tutuldu & w_tutuldu & ~BVALID;
    assign k_push        = yaz_hazir & (aw_adr == 2'd0) & ~k_dolu;
    assign k_pop         = komut_gecerli & komut_hazir;
    assign v_push        = veri_gecerli & veri_hazir;
    assign v_pop         = ar_hs & (ARADDR[3:2] == 2'd0) & ~v_bos;

    assign durum         = {14'd0, v_bos, k_dolu, v_say, k_say};

    // Byte lanes without a strobe are replaced by the fill byte
    always_comb begin
        k_birlesik = '0;
        for (int unsigned i = 0; i < NB; i++)
            k_birlesik[i*8 +: 8] = w_strb[i] ? w_veri[i*8 +: 8] : STRB_DOLGU;
    end

    // AW/W capture, push decision and B response
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_tutuldu <= 1'b0;
            w_tutuldu  <= 1'b0;
            aw_adr     <= '0;
            w_veri     <= '0;
            w_strb     <= '0;
            BVALID     <= 1'b0;
            BRESP      <= 2'b00;
        end else begin
            if (aw_hs) begin
                aw_tutuldu <= 1'b1;
                aw_adr     <= AWADDR[3:2];
            end
            if (w_hs) begin
                w_tutuldu <= 1'b1;
                w_veri    <= WDATA;
                w_strb    <= WSTRB;
            end
            if (yaz_hazir) begin
                if (aw_adr != 2'd0) begin
                    BVALID <= 1'b1;
                    BRESP  <= 2'b10;
                end else if (!k_dolu) begin
                    BVALID <= 1'b1;
                    BRESP  <= 2'b00;
                end
            end else if (BVALID && BREADY) begin
                BVALID     <= 1'b0;
                aw_tutuldu <= 1'b0;
                w_tutuldu  <= 1'b0;
            end
        end
    end

    // AR decode and R response held until RREADY
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= 2'b00;
        end else if (ar_hs) begin
            RVALID <= 1'b1;
            case (ARADDR[3:2])
                2'd0: begin
                    if (!v_bos) begin
                        RDATA <= v_mem[v_oku];
                        RRESP <= 2'b00;
                    end else begin
                        RDATA <= '0;
                        RRESP <= 2'b10;
                    end
                end
                2'd1: begin
                    RDATA <= VERI_BIT'(durum);
                    RRESP <= 2'b00;
                end
                default: begin
                    RDATA <= '0;
                    RRESP <= 2'b10;
                end
            endcase
        end else if (RVALID && RREADY) begin
            RVALID <= 1'b0;
        end
    end

    // Command FIFO storage
    always_ff @(posedge ACLK) begin
        if (k_push) k_mem[k_yaz] <= k_birlesik;
    end

    // Command FIFO pointers and occupancy
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            k_yaz <= '0;
            k_oku <= '0;
            k_say <= '0;
        end else begin
            if (k_push) k_yaz <= (k_yaz == K_SON) ? '0 : k_yaz + 1'b1;
            if (k_pop)  k_oku <= (k_oku == K_SON) ? '0 : k_oku + 1'b1;
            if (k_push && !k_pop)      k_say <= k_say + 8'd1;
            else if (!k_push && k_pop) k_say <= k_say - 8'd1;
        end
    end

    // Data FIFO storage
    always_ff @(posedge ACLK) begin
        if (v_push) v_mem[v_yaz] <= veri;
    end

    // Data FIFO pointers and occupancy
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            v_yaz <= '0;
            v_oku <= '0;
            v_say <= '0;
        end else begin
            if (v_push) v_yaz <= (v_yaz == V_SON) ? '0 : v_yaz + 1'b1;
            if (v_pop)  v_oku <= (v_oku == V_SON) ? '0 : v_oku + 1'b1;
            if (v_push && !v_pop)      v_say <= v_say + 8'd1;
            else if (!v_push && v_pop) v_say <= v_say - 8'd1;
        end
    end

endmodule

// File: tb/tb_axil_gfi_fifo_kopru.sv
// Self-checking bench: transaction-level model (queues) compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.
`timescale 1ns/1ps
module tb_axil_gfi_fifo_kopru;

    localparam int KD = 4;
    localparam int VD = 3;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA, komut, veri;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic        komut_gecerli, komut_hazir, veri_gecerli, veri_hazir;

    int total = 0;
    int bad   = 0;

    axil_gfi_fifo_kopru #(
        .ADRES_BIT(32), .VERI_BIT(32), .KOMUT_DER(KD), .VERI_DER(VD), .STRB_DOLGU(8'hFF)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .komut(komut), .komut_gecerli(komut_gecerli), .komut_hazir(komut_hazir),
        .veri(veri), .veri_gecerli(veri_gecerli), .veri_hazir(veri_hazir)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_awh, m_wh, m_bv, m_rv;
    logic [1:0]  m_awa, m_br, m_rr;
    logic [31:0] m_wd, m_rd;
    logic [3:0]  m_ws;
    logic [31:0] kq[$];
    logic [31:0] vq[$];

    function automatic logic [31:0] birlestir(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = s[i] ? d[i*8 +: 8] : 8'hFF;
        return r;
    endfunction

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            m_awh = 0; m_wh = 0; m_bv = 0; m_rv = 0;
            m_br = 0; m_rr = 0; m_rd = 0;
            kq.delete(); vq.delete();
        end else begin
            bit aw_f, w_f, ar_f, kpop, vpush, vpop, kpush;
            logic [31:0] kval;
            aw_f  = AWVALID && !m_awh && !m_bv;
            w_f   = WVALID && !m_wh && !m_bv;
            ar_f  = ARVALID && !m_rv;
            kpop  = (kq.size() != 0) && komut_hazir;
            vpush = veri_gecerli && (vq.size() < VD);
            vpop  = 0;
            kpush = 0;
            kval  = birlestir(m_wd, m_ws);
            if (m_awh && m_wh && !m_bv) begin
                if (m_awa != 0) begin m_bv = 1; m_br = 2'b10; end
                else if (kq.size() < KD) begin m_bv = 1; m_br = 2'b00; kpush = 1; end
            end else if (m_bv && BREADY) begin
                m_bv = 0; m_awh = 0; m_wh = 0;
            end
            if (aw_f) begin m_awh = 1; m_awa = AWADDR[3:2]; end
            if (w_f)  begin m_wh = 1; m_wd = WDATA; m_ws = WSTRB; end
            if (ar_f) begin
                m_rv = 1;
                if (ARADDR[3:2] == 0) begin
                    if (vq.size() != 0) begin m_rd = vq[0]; m_rr = 0; vpop = 1; end
                    else begin m_rd = 0; m_rr = 2'b10; end
                end else if (ARADDR[3:2] == 1) begin
                    m_rd = {14'd0, vq.size() == 0, kq.size() == KD, 8'(vq.size()), 8'(kq.size())};
                    m_rr = 0;
                end else begin
                    m_rd = 0; m_rr = 2'b10;
                end
            end else if (m_rv && RREADY) begin
                m_rv = 0;
            end
            if (kpop)  void'(kq.pop_front());
            if (kpush) kq.push_back(kval);
            if (vpop)  void'(vq.pop_front());
            if (vpush) vq.push_back(veri);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge ACLK) begin
        chk("awready", AWREADY, ARESETn && !m_awh && !m_bv);
        chk("wready", WREADY, ARESETn && !m_wh && !m_bv);
        chk("arready", ARREADY, ARESETn && !m_rv);
        chk("bvalid", BVALID, m_bv);
        if (m_bv) chk("bresp", BRESP, m_br);
        chk("rvalid", RVALID, m_rv);
        if (m_rv) begin
            chk("rdata", RDATA, m_rd);
            chk("rresp", RRESP, m_rr);
        end
        chk("komut_gecerli", komut_gecerli, kq.size() != 0);
        if (kq.size() != 0) chk("komut", komut, kq[0]);
        chk("veri_hazir", veri_hazir, ARESETn && (vq.size() < VD));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] s,
                             input int lead, input int budget, input bit brdy,
                             output logic [1:0] resp, output bit done);
        bit awf, wf, bf;
        done = 0; resp = '0;
        WVALID = 1; WDATA = d; WSTRB = s; AWADDR = adr; AWVALID = (lead == 0); BREADY = brdy;
        for (int c = 0; c < budget; c++) begin
            @(negedge ACLK);
            awf = AWVALID && AWREADY;
            wf  = WVALID && WREADY;
            bf  = BVALID && BREADY;
            if (bf) resp = BRESP;
            tick();
            if (awf) AWVALID = 0;
            if (wf)  WVALID = 0;
            if (lead > 0 && c + 1 == lead) AWVALID = 1;
            if (bf) begin done = 1; break; end
        end
    endtask

    task automatic wait_b(input int budget, output logic [1:0] resp, output bit done);
        done = 0; resp = '0; BREADY = 1;
        for (int c = 0; c < budget; c++) begin
            @(negedge ACLK);
            if (BVALID) begin resp = BRESP; done = 1; end
            tick();
            if (done) break;
        end
    endtask

    task automatic axi_read(input logic [31:0] adr, output logic [31:0] d,
                            output logic [1:0] resp, output bit done);
        bit arf, rf;
        done = 0; d = '0; resp = '0;
        ARADDR = adr; ARVALID = 1; RREADY = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge ACLK);
            arf = ARVALID && ARREADY;
            rf  = RVALID && RREADY;
            if (rf) begin d = RDATA; resp = RRESP; end
            tick();
            if (arf) ARVALID = 0;
            if (rf) begin done = 1; break; end
        end
    endtask

    task automatic push_veri(input logic [31:0] val);
        bit f;
        f = 0;
        veri = val; veri_gecerli = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge ACLK);
            f = veri_hazir;
            tick();
            if (f) break;
        end
        veri_gecerli = 0;
        chk("veri_push_done", f, 1);
    endtask

    function automatic logic [31:0] rnd_adr();
        case ($urandom_range(0, 5))
            0, 1, 2: return 32'h0;
            3:       return 32'h4;
            4:       return 32'h8;
            default: return 32'hC;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        bit          ok;

        ARESETn = 0;
        AWADDR = 0; AWPROT = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
        ARADDR = 0; ARPROT = 0; ARVALID = 0; RREADY = 0;
        komut_hazir = 0; veri = 0; veri_gecerli = 0;
        repeat (3) tick();

        // Reset state
        chk("rst_bvalid", BVALID, 0);
        chk("rst_bresp", BRESP, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_rresp", RRESP, 0);
        chk("rst_komut", komut, 0);
        chk("rst_komut_gecerli", komut_gecerli, 0);
        chk("rst_veri_hazir", veri_hazir, 0);
        chk("rst_awready", AWREADY, 0);
        ARESETn = 1;
        tick();

        // 1: full-strobe command write
        axi_write(32'h0, 32'h11223344, 4'hF, 0, 20, 1, r, ok);
        chk("t1_done", ok, 1);
        chk("t1_bresp", r, 2'b00);
        chk("t1_komut", komut, 32'h11223344);
        komut_hazir = 1; tick(); komut_hazir = 0;
        chk("t1_popped", komut_gecerli, 0);

        // 2: partial strobes fill with 0xFF
        axi_write(32'h0, 32'hAABBCCDD, 4'b0101, 0, 20, 1, r, ok);
        chk("t2_done", ok, 1);
        chk("t2_komut", komut, 32'hFFBBFFDD);
        komut_hazir = 1; tick(); komut_hazir = 0;

        // 3: W leads AW; fill past depth, last B stalls until a pop
        for (int i = 0; i < KD; i++) begin
            axi_write(32'h0, 32'h100 + i, 4'hF, 3, 30, 1, r, ok);
            chk("t3_fill_done", ok, 1);
        end
        axi_write(32'h0, 32'h1FF, 4'hF, 3, 12, 1, r, ok);
        chk("t3_stalled", ok, 0);
        chk("t3_bvalid_low", BVALID, 0);
        chk("t3_head", komut, 32'h100);
        komut_hazir = 1; tick(); komut_hazir = 0;
        wait_b(10, r, ok);
        chk("t3_released", ok, 1);
        chk("t3_bresp", r, 2'b00);
        komut_hazir = 1; repeat (8) tick(); komut_hazir = 0;

        // 4: data FIFO reads, empty poll gives SLVERR
        push_veri(32'd5);
        push_veri(32'd6);
        axi_read(32'h0, d, r, ok); chk("t4_r1", {r, d}, {2'b00, 32'd5});
        axi_read(32'h0, d, r, ok); chk("t4_r2", {r, d}, {2'b00, 32'd6});
        axi_read(32'h0, d, r, ok); chk("t4_r3", {r, d}, {2'b10, 32'd0});
        axi_read(32'h4, d, r, ok); chk("t4_status", {r, d}, {2'b00, 32'h0002_0000});

        // 5: undecoded addresses
        axi_read(32'h8, d, r, ok); chk("t5_rd8", {r, d}, {2'b10, 32'd0});
        axi_write(32'hC, 32'hDEADBEEF, 4'hF, 0, 20, 1, r, ok);
        chk("t5_wrC", r, 2'b10);
        axi_read(32'h4, d, r, ok); chk("t5_status", {r, d}, {2'b00, 32'h0002_0000});

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            bit awf, wf, arf;
            @(negedge ACLK);
            awf = AWVALID && AWREADY;
            wf  = WVALID && WREADY;
            arf = ARVALID && ARREADY;
            tick();
            if (awf) AWVALID = 0;
            if (wf)  WVALID = 0;
            if (arf) ARVALID = 0;
            if (!AWVALID && $urandom_range(0, 2) == 0) begin AWVALID = 1; AWADDR = rnd_adr(); end
            if (!WVALID && $urandom_range(0, 2) == 0) begin
                WVALID = 1; WDATA = $urandom; WSTRB = 4'($urandom_range(0, 15));
            end
            if (!ARVALID && $urandom_range(0, 2) == 0) begin ARVALID = 1; ARADDR = rnd_adr(); end
            BREADY       = ($urandom_range(0, 3) != 0);
            RREADY       = ($urandom_range(0, 3) != 0);
            komut_hazir  = ($urandom_range(0, 2) == 0);
            veri_gecerli = ($urandom_range(0, 1) == 0);
            veri         = $urandom;
        end

        // Let outstanding transfers complete
        begin
            bit pend;
            pend = 1;
            for (int c = 0; c < 200; c++) begin
                bit awf, wf, arf;
                @(negedge ACLK);
                awf = AWVALID && AWREADY;
                wf  = WVALID && WREADY;
                arf = ARVALID && ARREADY;
                pend = AWVALID || WVALID || ARVALID || BVALID || RVALID || komut_gecerli;
                tick();
                if (awf) AWVALID = 0;
                if (wf)  WVALID = 0;
                if (arf) ARVALID = 0;
                komut_hazir = 1; veri_gecerli = 0; BREADY = 1; RREADY = 1;
                if (!pend) break;
            end
            chk("settle", pend, 0);
            komut_hazir = 0;
        end

        // 6: asynchronous reset with BVALID high and two commands queued
        axi_write(32'h0, 32'hA5A5_0001, 4'hF, 0, 20, 1, r, ok);
        chk("t6_w1", ok, 1);
        axi_write(32'h0, 32'hA5A5_0002, 4'hF, 0, 6, 0, r, ok);
        chk("t6_bvalid_pre", BVALID, 1);
        chk("t6_komut_pre", komut, 32'hA5A5_0001);
        @(posedge ACLK); #2;
        ARESETn = 0;
        #1;
        chk("t6_bvalid", BVALID, 0);
        chk("t6_komut_gecerli", komut_gecerli, 0);
        chk("t6_rvalid", RVALID, 0);
        tick();
        ARESETn = 1;
        BREADY = 1;
        tick();
        axi_read(32'h4, d, r, ok);
        chk("t6_status", {r, d}, {2'b00, 32'h0002_0000});
        repeat (3) tick();
        chk("t6_no_stale_b", BVALID, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
